// File: rtl/output_write_buffer.sv
// Circular FIFO output buffer downstream of the write-buffer controller.
// It captures result words on the write strobe and returns them through a registered read port.
module output_write_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_rst,
  input  logic              write_req,
  input  logic              write_in_buffer,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  input  logic              read_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [ADDR_W:0] DEPTH_C = ADDR_W'(DEPTH) | ((ADDR_W+1)'(DEPTH));
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              clr;
  logic              wr_ok;
  logic              rd_ok;

  // write_req only qualifies the handshake upstream and has no effect on state.
  logic unused_write_req;
  assign unused_write_req = write_req;

  assign clr         = rst | inner_rst;
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_C);
  assign ready       = ~full;
  assign wr_ok       = write_in_buffer & ~full;
  assign rd_ok       = read_en & ~empty;

  // NOTE: storage has no reset; clearing the pointers is enough to empty the buffer and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      dout_valid <= rd_ok;
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (write_in_buffer && full) begin
        overflow_err <= 1'b1;
      end
      if (read_en && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/output_write_buffer.md
Name: output_write_buffer

Overview:
- Circular FIFO output buffer that sits directly downstream of the write-buffer controller.
- Accepts result words (PAR_W wide) when the controller pulses its write strobe after a write_req/ready handshake.
- Holds the words until the consumer side (host/memory writer) drains them with read_en.
- Generates the ready back-pressure signal the controller stalls on.

Parameters:
- DATA_W, 16, width of each stored word.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- ADDR_W, 3, pointer width; equals log2(DEPTH).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inner_rst  in  1  synchronous, active-high per-layer clear; same effect as rst.
- write_req  in  1  controller request to write; qualifies ready only (informational, no state effect).
- write_in_buffer  in  1  write strobe; captures din this cycle.
- din  in  DATA_W  write data.
- ready  out  1  asserted when the buffer can accept a write this cycle.
- read_en  in  1  consumer read request.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  dout holds a newly read word.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- overflow_err  out  1  sticky; a write was attempted while full.
- underflow_err  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (rst or inner_rst high at an edge) sets wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow_err=0, underflow_err=0.
  - After reset: empty=1, full=0, almost_full=0, ready=1.
  - Storage contents are not cleared.
- Reset has priority over any simultaneous read or write. A write or read in the reset cycle is discarded and does not set the error flags.
- ready is combinational and equals !full. It does not depend on write_req or read_en, so the controller sees a stable value for the whole cycle.
- Write accepted when write_in_buffer=1 and full=0, evaluated at the start of the cycle:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Write with full=1: write is dropped, pointers are unchanged, overflow_err <= 1.
- Read accepted when read_en=1 and empty=0:
  - dout <= mem[rd_ptr] and dout_valid <= 1 on the same edge, so data is visible the cycle after read_en (latency 1).
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Read with empty=1: no data; dout holds its previous value, dout_valid <= 0, underflow_err <= 1.
- dout_valid is a one-cycle pulse per accepted read. It is 0 in any cycle following no accepted read.
- Simultaneous write and read:
  - Neither full nor empty: both accepted, count unchanged, pointers both advance.
  - full: read accepted, write dropped and overflow_err set. No same-cycle bypass; the controller must not have strobed because ready was 0.
  - empty: write accepted, read rejected with underflow_err set. No write-to-read bypass; the word is readable from the next cycle.
- count update:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged otherwise.
  - Never exceeds DEPTH and never wraps below 0.
- full, empty and almost_full are decoded combinationally from the registered count.
- Pointer wrap: after DEPTH accepted writes, wr_ptr returns to 0. Data ordering is strict FIFO across the wrap.
- overflow_err and underflow_err clear only on rst or inner_rst.
- Structure: no FSM beyond pointer/count registers. Single clock domain.

Test Plan:
- Reset, then 3 writes din=0x0011, 0x0022, 0x0033, then 3 reads -> count 1,2,3 then 2,1,0; dout=0x0011, 0x0022, 0x0033, each with dout_valid one cycle after its read_en; empty=1 at end.
- Fill 8 words with no reads -> almost_full rises when count=6; full=1 and ready=0 at count=8. A 9th write strobe -> dropped, overflow_err=1, count stays 8.
- Full buffer with write_in_buffer=1 and read_en=1 in the same cycle -> first word read out, write dropped, count=7, overflow_err=1.
- Empty buffer with write=0x00AA and read_en=1 in the same cycle -> underflow_err=1, dout_valid=0, count=1. Read on the next cycle -> dout=0x00AA.
- Wrap check: 6 writes, 6 reads, then 5 writes (wr_ptr wraps to 3) and 5 reads -> data returned in write order, count=0, no error flags.
- Buffer with count=4 and error flags set, pulse inner_rst for one cycle alongside a write -> count=0, empty=1, both error flags=0, dout_valid=0; the write is not stored.
